// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared defaults and encodings for the RAM requester arbiter
// Contents: requester count / tag width defaults, access type encoding,
//           default burst-lock length. No ports.
package ram_arb_pkg;

  localparam int RAM_REQ_NUM  = 4;
  localparam int RAM_ID_WD    = 2;
  localparam int RAM_LOCK_MAX = 16;

  // Encoding of one wr_i bit.
  typedef enum logic {
    ACC_RD = 1'b0,
    ACC_WR = 1'b1
  } acc_e;

endpackage

// File: rtl/rr_arb_core.sv
// rtl/rr_arb_core.sv - combinational round-robin picker
// Ports:
//   req_i  in  N    request vector
//   ptr_i  in  IW   index the search starts from (wraps N-1 -> 0)
//   gnt_o  out N    one-hot grant, all zero when nothing requests
//   id_o   out IW   encoded winner index (0 when nothing requests)
//   vld_o  out 1    a winner exists
module rr_arb_core #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] id_o,
  output logic          vld_o
);

  always_comb begin
    int idx;
    gnt_o = '0;
    id_o  = '0;
    vld_o = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!vld_o && req_i[idx]) begin
        vld_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/ram_sp_be_arb.sv
// rtl/ram_sp_be_arb.sv - round-robin arbiter onto one single-port bit-enable RAM
// Optional macro RAM_ARB_LOCK_EN: enables the bounded burst lock driven by lock_i.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_i/wr_i/lock_i   per-requester request, write(1)/read(0), burst lock
//   adr_i/wr_ena_i/wr_dat_i  packed per-requester address, bit-enable, write data
//   gnt_o               one-hot grant, combinational, zero during reset
//   rd_vld_o/rd_id_o/rd_dat_o  read return, one cycle after an accepted read
//   ram_*               direct connection to the RAM wrapper
module ram_sp_be_arb
  import ram_arb_pkg::*;
#(
  parameter int REQ_NUM  = RAM_REQ_NUM,
  parameter int ADR_WD   = 7,
  parameter int DAT_WD   = 64,
  parameter int ID_WD    = RAM_ID_WD,
  parameter int LOCK_MAX = RAM_LOCK_MAX
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REQ_NUM-1:0]        req_i,
  input  logic [REQ_NUM-1:0]        wr_i,
  input  logic [REQ_NUM-1:0]        lock_i,
  input  logic [REQ_NUM*ADR_WD-1:0] adr_i,
  input  logic [REQ_NUM*DAT_WD-1:0] wr_ena_i,
  input  logic [REQ_NUM*DAT_WD-1:0] wr_dat_i,
  output logic [REQ_NUM-1:0]        gnt_o,
  output logic                      rd_vld_o,
  output logic [ID_WD-1:0]          rd_id_o,
  output logic [DAT_WD-1:0]         rd_dat_o,
  output logic [ADR_WD-1:0]         ram_adr_o,
  output logic [DAT_WD-1:0]         ram_wr_ena_o,
  output logic [DAT_WD-1:0]         ram_wr_dat_o,
  output logic                      ram_rd_ena_o,
  input  logic [DAT_WD-1:0]         ram_rd_dat_i
);

  logic [ID_WD-1:0]  ptr_q, ptr_d;
  logic              rd_vld_q, rd_vld_d;
  logic [ID_WD-1:0]  rd_id_q, rd_id_d;
  logic [ADR_WD-1:0] adr_q, adr_d;

  logic [REQ_NUM-1:0] rr_gnt;
  logic [ID_WD-1:0]   rr_id;
  logic               rr_vld;

  logic [ID_WD-1:0] win_id;
  logic             win_vld;
  logic             win_wr;
  logic             locked;

  rr_arb_core #(
    .N  (REQ_NUM),
    .IW (ID_WD)
  ) u_rr_arb_core (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .id_o  (rr_id),
    .vld_o (rr_vld)
  );

`ifdef RAM_ARB_LOCK_EN
  localparam int CNT_WD = $clog2(LOCK_MAX + 1);

  logic              lock_vld_q, lock_vld_d;
  logic [ID_WD-1:0]  lock_id_q, lock_id_d;
  logic [CNT_WD-1:0] lock_cnt_q, lock_cnt_d;

  // A lock only takes effect while its owner keeps requesting.
  assign locked = lock_vld_q & req_i[lock_id_q];

  always_comb begin
    lock_vld_d = 1'b0;
    lock_id_d  = lock_id_q;
    lock_cnt_d = '0;
    if (win_vld && lock_i[win_id]) begin
      lock_id_d  = win_id;
      lock_cnt_d = locked ? lock_cnt_q + 1'b1 : CNT_WD'(1);
      // Limit reached: skip the lock for one arbitration so rr resumes at k+1.
      if (lock_cnt_d >= CNT_WD'(LOCK_MAX)) begin
        lock_cnt_d = '0;
      end else begin
        lock_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_vld_q <= 1'b0;
      lock_id_q  <= '0;
      lock_cnt_q <= '0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock_i;
  assign locked      = 1'b0;
`endif

  always_comb begin
    win_id  = rr_id;
    win_vld = rr_vld;
`ifdef RAM_ARB_LOCK_EN
    if (locked) begin
      win_id  = lock_id_q;
      win_vld = 1'b1;
    end
`endif
    if (rst) begin
      win_vld = 1'b0;
    end
    win_wr = (wr_i[win_id] == ACC_WR);

    gnt_o        = win_vld ? (REQ_NUM'(1) << win_id) : '0;
    ram_adr_o    = win_vld ? adr_i[int'(win_id)*ADR_WD +: ADR_WD] : adr_q;
    ram_wr_dat_o = wr_dat_i[int'(win_id)*DAT_WD +: DAT_WD];
    ram_wr_ena_o = (win_vld && win_wr) ? wr_ena_i[int'(win_id)*DAT_WD +: DAT_WD] : '0;
    ram_rd_ena_o = win_vld && !win_wr;

    adr_d    = ram_adr_o;
    rd_vld_d = ram_rd_ena_o;
    rd_id_d  = ram_rd_ena_o ? win_id : rd_id_q;

    // Locked grants leave the pointer where the lock owner's first grant put it.
    ptr_d = ptr_q;
    if (win_vld && !locked) begin
      ptr_d = (win_id == ID_WD'(REQ_NUM - 1)) ? '0 : win_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_id_q  <= '0;
      adr_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rd_vld_q <= rd_vld_d;
      rd_id_q  <= rd_id_d;
      adr_q    <= adr_d;
    end
  end

  // A read accepted just before reset must not surface during the reset cycle.
  assign rd_vld_o = rd_vld_q & ~rst;
  assign rd_id_o  = rst ? '0 : rd_id_q;
  assign rd_dat_o = ram_rd_dat_i;

endmodule
